// File: rtl/bcd_pkg.sv
// Shared constants, FSM state encodings and helpers for the packed-BCD serial adder.
package bcd_pkg;

  // Width of one BCD digit, largest legal digit value, and decimal correction.
  localparam int BCD_W    = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  // FSM state encodings: IDLE waits for start, RUN adds one digit per cycle,
  // DONE presents the one-cycle completion pulse.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // True when a 4-bit code is not a legal BCD digit.
  function automatic logic digit_invalid(input logic [BCD_W-1:0] d);
    return d > BCD_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD adder stage. Non-BCD inputs follow the same
// correction rule so the result is always deterministic.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a_d,
  input  logic [BCD_W-1:0] b_d,
  input  logic             c_in,
  output logic [BCD_W-1:0] s,
  output logic             c_out
);

  logic [BCD_W:0] t;

  // Binary sum, then add 6 (mod 16) whenever it exceeds 9 to wrap into decimal.
  always_comb begin
    t     = {1'b0, a_d} + {1'b0, b_d} + {{BCD_W{1'b0}}, c_in};
    s     = t[BCD_W-1:0];
    c_out = 1'b0;
    if (t > (BCD_W + 1)'(BCD_MAX)) begin
      s     = t[BCD_W-1:0] + BCD_W'(BCD_CORR);
      c_out = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder: operands are latched on start, then summed one
// digit per clock (LSD first) through a single shared digit stage.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BCD_W*DIGITS-1:0]   a,
  input  logic [BCD_W*DIGITS-1:0]   b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   sum,
  output logic                      cout,
  output logic                      invalid
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] index_reg;
  logic             carry_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic             cout_reg;
  logic             invalid_reg;

  logic [BCD_W-1:0]    a_dig [DIGITS];
  logic [BCD_W-1:0]    b_dig [DIGITS];
  logic [2*DIGITS-1:0] digit_bad;
  logic [BCD_W-1:0]    stage_s;
  logic                stage_c;

  // Per-digit views of the latched operands and legality flags of the live inputs.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digits
      assign a_dig[gi]            = a_reg[gi*BCD_W +: BCD_W];
      assign b_dig[gi]            = b_reg[gi*BCD_W +: BCD_W];
      assign digit_bad[gi]        = digit_invalid(a[gi*BCD_W +: BCD_W]);
      assign digit_bad[DIGITS+gi] = digit_invalid(b[gi*BCD_W +: BCD_W]);
    end
  endgenerate

  // Single shared digit stage, steered by the current digit index.
  bcd_digit_add u_stage (
    .a_d   (a_dig[index_reg]),
    .b_d   (b_dig[index_reg]),
    .c_in  (carry_reg),
    .s     (stage_s),
    .c_out (stage_c)
  );

  // Control FSM, operand capture and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      index_reg   <= '0;
      carry_reg   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
      invalid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg       <= a;
            b_reg       <= b;
            carry_reg   <= cin;
            index_reg   <= '0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
            invalid_reg <= |digit_bad;
            state_reg   <= RUN;
          end
        end
        RUN: begin
          sum_reg[index_reg*BCD_W +: BCD_W] <= stage_s;
          carry_reg <= stage_c;
          if (index_reg == LAST_IDX) begin
            cout_reg  <= stage_c;
            state_reg <= DONE;
          end else begin
            index_reg <= index_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Status and results come straight from registers so they are glitch-free.
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign sum     = sum_reg;
  assign cout    = cout_reg;
  assign invalid = invalid_reg;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder (DIGITS=4).
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        invalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One full operation; samples on falling edges after start edge 0..6.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] es, input logic ec, input logic ei);
    int busy_n;
    int done_n;
    int done_at;
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
    end
    chk({tag, ".busy_cycles"}, busy_n, 5);
    chk({tag, ".done_pulses"}, done_n, 1);
    chk({tag, ".done_edge"}, done_at, 4);
    chk({tag, ".sum"}, {16'h0, sum}, {16'h0, es});
    chk({tag, ".cout"}, {31'h0, cout}, {31'h0, ec});
    chk({tag, ".invalid"}, {31'h0, invalid}, {31'h0, ei});
    $display("op %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d invalid=%0d (exp %h %0d %0d)",
             tag, av, bv, cv, sum, cout, invalid, es, ec, ei);
  endtask

  initial begin
    int done_n;
    int done_at;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.busy", {31'h0, busy}, 0);
    chk("reset.done", {31'h0, done}, 0);
    chk("reset.sum", {16'h0, sum}, 0);
    chk("reset.cout", {31'h0, cout}, 0);
    chk("reset.invalid", {31'h0, invalid}, 0);
    $display("reset: busy=%0d done=%0d sum=%h cout=%0d invalid=%0d", busy, done, sum, cout, invalid);

    // 1. zeros
    run_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

    // 2. carry ripple and full wrap
    run_op("ripple", 16'h0699, 16'h0009, 1'b0, 16'h0708, 1'b0, 1'b0);
    // result held while idle, regardless of input changes
    a = 16'h1111; b = 16'h2222; cin = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold.sum", {16'h0, sum}, {16'h0, 16'h0708});
    chk("hold.busy", {31'h0, busy}, 0);
    $display("hold: sum=%h busy=%0d", sum, busy);
    run_op("wrap", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    // 3. carry-in and maximum operands
    run_op("cin", 16'h1234, 16'h5678, 1'b1, 16'h6913, 1'b0, 1'b0);
    run_op("max", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);

    // 4. start while busy is ignored; operand changes after load have no effect
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h5555; b = 16'h5555; cin = 1'b1;
    done_n = 0; done_at = -1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 4) start = 1'b0;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
    end
    chk("busy_start.done_pulses", done_n, 1);
    chk("busy_start.done_edge", done_at, 4);
    chk("busy_start.sum", {16'h0, sum}, {16'h0, 16'h0002});
    chk("busy_start.cout", {31'h0, cout}, 0);
    $display("op busy_start: sum=%h cout=%0d done_pulses=%0d", sum, cout, done_n);

    // 5. reset mid-run aborts with no done pulse
    a = 16'h9999; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", {31'h0, busy}, 0);
    chk("abort.done", {31'h0, done}, 0);
    chk("abort.sum", {16'h0, sum}, 0);
    chk("abort.cout", {31'h0, cout}, 0);
    done_n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("abort.no_done", done_n, 0);
    $display("op abort: busy=%0d sum=%h cout=%0d late_done=%0d", busy, sum, cout, done_n);
    run_op("after_abort", 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0);

    // 6. invalid digit flagged and processed with the same rule, then cleared
    run_op("invalid", 16'h00F0, 16'h0000, 1'b0, 16'h0150, 1'b0, 1'b1);
    run_op("clear_inv", 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Multi-digit packed-BCD adder. It accepts two DIGITS-wide BCD operands and a carry-in through a start/done handshake, then adds them one digit per clock, least-significant digit first. The digit stage uses the same rule as the team's 1-digit BCD adder. The result and carry-out are registered and held stable for the downstream consumer.

Parameters:
DIGITS, 4, number of BCD digits per operand (minimum 2).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
a  input  4*DIGITS  operand A, packed BCD; a[3:0] is the least-significant digit.
b  input  4*DIGITS  operand B, same packing as a.
cin  input  1  carry-in to digit 0.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse when sum and cout are valid.
sum  output  4*DIGITS  packed BCD result, same packing as a.
cout  output  1  carry out of the most-significant digit.
invalid  output  1  any operand digit >9 at load; held with the result.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, index=0, carry=0.
  - sum=0, cout=0, done=0, busy=0, invalid=0.
  - Reset overrides everything, including mid-RUN; any in-flight operation is aborted with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a, b into internal registers; carry<=cin; index<=0; sum<=0; cout<=0.
  - invalid<=OR over all 2*DIGITS digits of (digit>9); go to RUN.
  - start=0: hold all outputs unchanged. The previous result stays visible.
- RUN, at each edge:
  - Compute digit stage on A[index], B[index], carry; write result to sum[index]; carry<=digit carry.
  - If index==DIGITS-1: cout<=digit carry, go to DONE; else index<=index+1.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE with done=0.
- Digit stage rule (combinational):
  - t = a_d + b_d + c, 5-bit.
  - If t>9: s=(t+6)[3:0], c_out=1. Else s=t[3:0], c_out=0.
  - Invalid digits use the same rule, so the result is deterministic (e.g. F+F+1 -> s=5, c=1).
- Latency:
  - start sampled at edge 0; digit i is written at edge i+1.
  - done is high during the cycle following edge DIGITS. For DIGITS=4, done is visible after edge 4 and drops at edge 5.
  - Next start can be accepted at edge DIGITS+2 at the earliest (back-to-back rate DIGITS+2 cycles).
- start while busy (RUN or DONE) is ignored; no queueing.
- Changes on a, b, cin after load have no effect on the operation in progress.
- sum, cout and invalid remain stable from done until the next accepted start, which clears sum and cout.
- busy = (state != IDLE), driven from registered state.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Constants BCD_W=4, BCD_MAX=9, BCD_CORR=6.
- Sub-module bcd_digit_add: purely combinational 1-digit stage; inputs a_d, b_d, c_in; outputs s, c_out. Instantiate it once in the top level, fed by muxes selected by index.
- Top level holds the FSM, index counter, operand registers and result register.

Test Plan (DIGITS=4):
1. a=0000, b=0000, cin=0, pulse start -> done one cycle after edge 4; sum=0000, cout=0, invalid=0, busy high for 5 cycles.
2. a=0699, b=0009, cin=0 -> sum=0708, cout=0. Then a=9999, b=0001, cin=0 -> sum=0000, cout=1.
3. a=1234, b=5678, cin=1 -> sum=6913, cout=0. Then a=9999, b=9999, cin=1 -> sum=9999, cout=1.
4. Start accepted for 0001+0001; assert start again with a=5555 at edges 1-4 -> ignored; sum=0002, cout=0; exactly one done pulse.
5. Start 9999+0001; assert rst at edge 2 -> next cycle state IDLE, busy=0, sum=0000, cout=0, no done. Then a fresh start of 0005+0004 -> sum=0009.
6. a=00F0, b=0000, cin=0 -> invalid=1 and sum=0150 (F+0 -> s=5, c=1), cout=0. Next accepted start of valid operands clears invalid to 0.
